// File: rtl/pong_pkg.sv
// Shared types and constants for the pong input path: debounce FSM states,
// the default debounce length and the button/channel index map.
package pong_pkg;

    typedef enum logic [1:0] {
        LO     = 2'd0,
        CHK_HI = 2'd1,
        HI     = 2'd2,
        CHK_LO = 2'd3
    } db_state_e;

    localparam int DEFAULT_DEBOUNCE_CYCLES = 1000000;

    localparam int NUM_BTNS  = 4;
    localparam int BTN_P1_DN = 0;
    localparam int BTN_P1_UP = 1;
    localparam int BTN_P2_DN = 2;
    localparam int BTN_P2_UP = 3;

    // Channels 0..3 are the buttons, then the two slide switches.
    localparam int NUM_CH  = 6;
    localparam int CH_AUTO = 4;
    localparam int CH_BG   = 5;

endpackage

// File: rtl/debounce_ch.sv
// One debounce channel: 2-flop synchronizer followed by a LO/CHK_HI/HI/CHK_LO
// FSM that accepts a level only after DEBOUNCE_CYCLES consecutive equal samples.
module debounce_ch
    import pong_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int CNT_W           = 20
) (
    input  logic pclk,
    input  logic rst_n,
    input  logic raw_i,
    output logic level_o
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [1:0]       sync_q;
    logic             s;
    db_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= 2'b00;
            state_q <= LO;
            cnt_q   <= '0;
        end else begin
            sync_q  <= {sync_q[0], raw_i};
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign s = sync_q[1];

    // The sample that leaves a stable state counts as the first of the run,
    // so the counter enters CHK_* at 1 and the run completes at DEBOUNCE_CYCLES-1.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            LO: begin
                if (s) begin
                    state_d = CHK_HI;
                    cnt_d   = CNT_ONE;
                end else begin
                    cnt_d = '0;
                end
            end
            CHK_HI: begin
                if (!s) begin
                    state_d = LO;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = HI;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            HI: begin
                if (!s) begin
                    state_d = CHK_LO;
                    cnt_d   = CNT_ONE;
                end else begin
                    cnt_d = '0;
                end
            end
            CHK_LO: begin
                if (s) begin
                    state_d = HI;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = LO;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = LO;
                cnt_d   = '0;
            end
        endcase
    end

    assign level_o = (state_q == HI) || (state_q == CHK_LO);

endmodule

// File: rtl/btn_conditioner.sv
// Debounces the four pong buttons and two switches, and generates press pulses.
// Define PONG_BTN_LOCKOUT_EN to blank a player's buttons while both are held.
module btn_conditioner
    import pong_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int CNT_W           = 20
) (
    input  logic                pclk,
    input  logic                rst_n,
    input  logic [NUM_BTNS-1:0] btn_raw,
    input  logic                sw_auto_raw,
    input  logic                sw_bg_raw,
    output logic [NUM_BTNS-1:0] btns,
    output logic [NUM_BTNS-1:0] btns_press,
    output logic                auto,
    output logic                background
);

    logic [NUM_CH-1:0]   raw_all;
    logic [NUM_CH-1:0]   lvl;
    logic [NUM_BTNS-1:0] btns_d, btns_q;

    assign raw_all = {sw_bg_raw, sw_auto_raw, btn_raw};

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        debounce_ch #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W)
        ) u_ch (
            .pclk    (pclk),
            .rst_n   (rst_n),
            .raw_i   (raw_all[i]),
            .level_o (lvl[i])
        );
    end

    always_comb begin
        btns_d = lvl[NUM_BTNS-1:0];
`ifdef PONG_BTN_LOCKOUT_EN
        if (lvl[BTN_P1_DN] && lvl[BTN_P1_UP]) begin
            btns_d[BTN_P1_DN] = 1'b0;
            btns_d[BTN_P1_UP] = 1'b0;
        end
        if (lvl[BTN_P2_DN] && lvl[BTN_P2_UP]) begin
            btns_d[BTN_P2_DN] = 1'b0;
            btns_d[BTN_P2_UP] = 1'b0;
        end
`endif
    end

    // Pulses are taken from the final (post-lockout) levels so a blanked
    // button never produces a press.
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            btns_q <= '0;
        end else begin
            btns_q <= btns_d;
        end
    end

    assign btns       = btns_d;
    assign btns_press = btns_d & ~btns_q;
    assign auto       = lvl[CH_AUTO];
    assign background = lvl[CH_BG];

endmodule

// File: tb/tb_btn_conditioner.sv
// Directed bench for btn_conditioner with DEBOUNCE_CYCLES=4 (6-cycle acceptance latency).
// Compile with PONG_BTN_LOCKOUT_EN defined to exercise the pair lockout expectations.
module tb_btn_conditioner;

    logic       pclk;
    logic       rst_n;
    logic [3:0] btn_raw;
    logic       sw_auto_raw;
    logic       sw_bg_raw;
    logic [3:0] btns;
    logic [3:0] btns_press;
    logic       auto;
    logic       background;

    int passed = 0;
    int total  = 0;
    int press_cnt [4] = '{0, 0, 0, 0};

    btn_conditioner #(
        .DEBOUNCE_CYCLES (4),
        .CNT_W           (20)
    ) dut (
        .pclk        (pclk),
        .rst_n       (rst_n),
        .btn_raw     (btn_raw),
        .sw_auto_raw (sw_auto_raw),
        .sw_bg_raw   (sw_bg_raw),
        .btns        (btns),
        .btns_press  (btns_press),
        .auto        (auto),
        .background  (background)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    always @(negedge pclk) begin
        for (int i = 0; i < 4; i++)
            if (btns_press[i] === 1'b1) press_cnt[i]++;
    end

    // One step = next falling edge plus 1 ns, so the press monitor has updated.
    task automatic cyc(input int n);
        repeat (n) begin
            @(negedge pclk);
            #1;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; btn_raw = 4'hF; sw_auto_raw = 1'b1; sw_bg_raw = 1'b1;
        cyc(3);
        total++; if (btns !== 4'h0) $display("FAIL reset_btns got=%b exp=0000", btns); else passed++;
        total++; if (btns_press !== 4'h0) $display("FAIL reset_press got=%b exp=0000", btns_press); else passed++;
        total++; if (auto !== 1'b0) $display("FAIL reset_auto got=%b exp=0", auto); else passed++;
        total++; if (background !== 1'b0) $display("FAIL reset_bg got=%b exp=0", background); else passed++;
        btn_raw = 4'h0; sw_auto_raw = 1'b0; sw_bg_raw = 1'b0;
        rst_n = 1'b1;
        cyc(3);
        total++; if (btns !== 4'h0) $display("FAIL post_reset_btns got=%b exp=0000", btns); else passed++;
    endtask

    task automatic test_press;
        int p0;
        p0 = press_cnt[0];
        btn_raw[0] = 1'b1;
        cyc(5);
        total++; if (btns !== 4'b0000) $display("FAIL press_early got=%b exp=0000", btns); else passed++;
        cyc(1);
        total++; if (btns !== 4'b0001) $display("FAIL press_level got=%b exp=0001", btns); else passed++;
        total++; if (btns_press !== 4'b0001) $display("FAIL press_pulse got=%b exp=0001", btns_press); else passed++;
        cyc(1);
        total++; if (btns_press !== 4'b0000) $display("FAIL press_pulse_end got=%b exp=0000", btns_press); else passed++;
        btn_raw[0] = 1'b0;
        cyc(5);
        total++; if (btns !== 4'b0001) $display("FAIL release_early got=%b exp=0001", btns); else passed++;
        cyc(1);
        total++; if (btns !== 4'b0000) $display("FAIL release_level got=%b exp=0000", btns); else passed++;
        total++; if (press_cnt[0] - p0 !== 1) $display("FAIL press_count got=%0d exp=1", press_cnt[0] - p0); else passed++;
    endtask

    task automatic test_glitch;
        logic [19:0] pat;
        logic        seen;
        int          p2;
        pat  = 20'b0000_0000_0000_0111_0111;
        seen = 1'b0;
        p2   = press_cnt[2];
        for (int i = 0; i < 20; i++) begin
            btn_raw[2] = pat[i];
            cyc(1);
            seen |= btns[2];
        end
        total++; if (seen !== 1'b0) $display("FAIL glitch_level got=%b exp=0", seen); else passed++;
        total++; if (press_cnt[2] - p2 !== 0) $display("FAIL glitch_pulses got=%0d exp=0", press_cnt[2] - p2); else passed++;
    endtask

    task automatic test_hold_glitch;
        logic seen_low;
        int   p1;
        p1 = press_cnt[1];
        btn_raw[1] = 1'b1;
        cyc(8);
        total++; if (btns[1] !== 1'b1) $display("FAIL hold_level got=%b exp=1", btns[1]); else passed++;
        seen_low = 1'b0;
        btn_raw[1] = 1'b0;
        cyc(1);
        seen_low |= ~btns[1];
        btn_raw[1] = 1'b1;
        for (int i = 0; i < 12; i++) begin
            cyc(1);
            seen_low |= ~btns[1];
        end
        total++; if (seen_low !== 1'b0) $display("FAIL hold_glitch_drop got=%b exp=0", seen_low); else passed++;
        total++; if (press_cnt[1] - p1 !== 1) $display("FAIL hold_glitch_pulses got=%0d exp=1", press_cnt[1] - p1); else passed++;
        btn_raw[1] = 1'b0;
        cyc(8);
        total++; if (btns !== 4'b0000) $display("FAIL hold_release got=%b exp=0000", btns); else passed++;
    endtask

    task automatic test_switches;
        sw_auto_raw = 1'b1; sw_bg_raw = 1'b1;
        cyc(5);
        total++; if ({auto, background} !== 2'b00) $display("FAIL sw_early got=%b exp=00", {auto, background}); else passed++;
        cyc(1);
        total++; if ({auto, background} !== 2'b11) $display("FAIL sw_rise got=%b exp=11", {auto, background}); else passed++;
        total++; if (btns !== 4'b0000) $display("FAIL sw_btns_isolated got=%b exp=0000", btns); else passed++;
        sw_auto_raw = 1'b0; sw_bg_raw = 1'b0;
        cyc(6);
        total++; if ({auto, background} !== 2'b00) $display("FAIL sw_fall got=%b exp=00", {auto, background}); else passed++;
    endtask

    task automatic test_reset_abort;
        int p0, p3;
        p0 = press_cnt[0];
        p3 = press_cnt[3];
        btn_raw[0] = 1'b1;
        cyc(8);
        total++; if (btns !== 4'b0001) $display("FAIL abort_pre_btn0 got=%b exp=0001", btns); else passed++;
        btn_raw[3] = 1'b1;
        cyc(5);
        total++; if (btns !== 4'b0001) $display("FAIL abort_pre_btn3 got=%b exp=0001", btns); else passed++;
        rst_n = 1'b0;
        #1;
        total++; if (btns !== 4'b0000) $display("FAIL abort_async_btns got=%b exp=0000", btns); else passed++;
        total++; if (btns_press !== 4'b0000) $display("FAIL abort_async_press got=%b exp=0000", btns_press); else passed++;
        cyc(1);
        rst_n = 1'b1;
        cyc(5);
        total++; if (btns !== 4'b0000) $display("FAIL abort_relatch_early got=%b exp=0000", btns); else passed++;
        cyc(1);
        total++; if (btns !== 4'b1001) $display("FAIL abort_relatch got=%b exp=1001", btns); else passed++;
        total++; if (btns_press !== 4'b1001) $display("FAIL abort_relatch_pulse got=%b exp=1001", btns_press); else passed++;
        cyc(1);
        total++; if (press_cnt[3] - p3 !== 1) $display("FAIL abort_btn3_pulses got=%0d exp=1", press_cnt[3] - p3); else passed++;
        total++; if (press_cnt[0] - p0 !== 2) $display("FAIL abort_btn0_pulses got=%0d exp=2", press_cnt[0] - p0); else passed++;
        btn_raw = 4'h0;
        cyc(8);
        total++; if (btns !== 4'b0000) $display("FAIL abort_cleanup got=%b exp=0000", btns); else passed++;
    endtask

    task automatic test_pair;
        int p0, p1;
        logic [3:0] exp_both, exp_both_pulse, exp_after;
        int exp_p1;
`ifdef PONG_BTN_LOCKOUT_EN
        exp_both = 4'b0000; exp_both_pulse = 4'b0000; exp_after = 4'b0000; exp_p1 = 0;
`else
        exp_both = 4'b0011; exp_both_pulse = 4'b0011; exp_after = 4'b0011; exp_p1 = 1;
`endif
        p0 = press_cnt[0];
        p1 = press_cnt[1];
        btn_raw[1:0] = 2'b11;
        cyc(6);
        total++; if (btns !== exp_both) $display("FAIL pair_both got=%b exp=%b", btns, exp_both); else passed++;
        total++; if (btns_press !== exp_both_pulse) $display("FAIL pair_both_pulse got=%b exp=%b", btns_press, exp_both_pulse); else passed++;
        cyc(2);
        btn_raw[1] = 1'b0;
        cyc(5);
        total++; if (btns !== exp_after) $display("FAIL pair_release_early got=%b exp=%b", btns, exp_after); else passed++;
        cyc(1);
        total++; if (btns !== 4'b0001) $display("FAIL pair_release got=%b exp=0001", btns); else passed++;
        cyc(1);
        total++; if (press_cnt[0] - p0 !== 1) $display("FAIL pair_btn0_pulses got=%0d exp=1", press_cnt[0] - p0); else passed++;
        total++; if (press_cnt[1] - p1 !== exp_p1) $display("FAIL pair_btn1_pulses got=%0d exp=%0d", press_cnt[1] - p1, exp_p1); else passed++;
        btn_raw = 4'h0;
        cyc(8);
        total++; if (btns !== 4'b0000) $display("FAIL pair_cleanup got=%b exp=0000", btns); else passed++;
    endtask

    initial begin
        rst_n = 1'b0;
        btn_raw = 4'h0;
        sw_auto_raw = 1'b0;
        sw_bg_raw = 1'b0;
        test_reset();
        test_press();
        test_glitch();
        test_hold_glitch();
        test_switches();
        test_reset_abort();
        test_pair();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
